// File: rtl/wb_sram_fifo.sv
// wb_sram_fifo: Wishbone B4 leaf slave with a single-port SRAM region and an RX/TX streaming FIFO bridge.
// Optional macro WB_ERR_EN: out-of-range accesses terminate with err instead of a dummy ack.
module wb_sram_fifo #(
  parameter int SRAM_AW    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] wishbone_adr,
  input  logic [31:0] wishbone_dat_w,
  output logic [31:0] wishbone_dat_r,
  input  logic        wishbone_cyc,
  input  logic        wishbone_stb,
  input  logic        wishbone_we,
  input  logic        wishbone_sel,
  input  logic [2:0]  wishbone_cti,
  input  logic [1:0]  wishbone_bte,
  output logic        wishbone_ack,
  output logic        wishbone_err,
  input  logic [31:0] fifo_dat_rx,
  input  logic        fifo_stb_rx,
  output logic        fifo_wait_rx,
  output logic [31:0] fifo_dat_tx,
  output logic        fifo_stb_tx,
  output logic        fifo_wait_tx
);
  localparam int           FAW       = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0] FIFO_FULL = (FAW+1)'(FIFO_DEPTH);
  localparam logic [2:0]   CTI_INCR  = 3'b010;

  // Bus handshake: a beat completes in any cycle where cyc & stb & (ack | err).
  // ack/err are registered; in a burst the next beat is answered speculatively.
  typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_BURST} state_t;
  state_t state;

  function automatic logic is_sram(input logic [29:0] a);
    return !a[29];
  endfunction

  function automatic logic is_data(input logic [29:0] a);
    return a[29] && (a[28:0] == 29'd0);
  endfunction

  function automatic logic is_stat(input logic [29:0] a);
    return a[29] && (a[28:0] == 29'd1);
  endfunction

`ifdef WB_ERR_EN
  function automatic logic is_oor(input logic [29:0] a);
    return a[29] && (a[28:1] != 28'd0);
  endfunction
`endif

  logic [31:0]        sram [2**SRAM_AW];
  logic [31:0]        sram_q;
  logic [31:0]        reg_q;
  logic               rsel_sram;
  logic [31:0]        rx_mem [FIFO_DEPTH];
  logic [31:0]        tx_mem [FIFO_DEPTH];
  logic [FAW-1:0]     rx_rd, rx_wr, tx_rd, tx_wr;
  logic [FAW:0]       rx_count, tx_count;
  logic [FAW:0]       rx_count_nxt, tx_count_nxt;
  logic               tx_overflow;
  logic [29:0]        beat_adr;
  logic               beat_we;
  logic               rx_pend;

  logic               req, beat_done, beat_ok, start, cont, issue;
  logic [29:0]        nxt_adr;
  logic               nxt_err;
  logic               sram_wr, sram_rd;
  logic [SRAM_AW-1:0] sram_idx;
  logic               tx_push, tx_push_ok, tx_pop;
  logic               rx_push, rx_pop, rx_avail;
  logic [FAW-1:0]     rx_peek;
  logic [31:0]        status;
  logic               unused_bte;

  assign unused_bte = ^wishbone_bte;

  always_comb begin
    req       = wishbone_cyc & wishbone_stb;
    beat_done = req & (state != S_IDLE);
    beat_ok   = beat_done & wishbone_ack;
    start     = req & (state == S_IDLE);
    // A burst continues only if the completing beat is the one we predicted.
    cont      = beat_done & (state == S_BURST) & (wishbone_cti == CTI_INCR) &
                (wishbone_adr == beat_adr) & (wishbone_we == beat_we);
    issue     = start | cont;
    // The FIFO data and status windows are fixed addresses: bursts stream them in place.
    nxt_adr   = start ? wishbone_adr :
                (is_sram(beat_adr) ? beat_adr + 30'd1 : beat_adr);
`ifdef WB_ERR_EN
    nxt_err   = is_oor(nxt_adr);
`else
    nxt_err   = 1'b0;
`endif
    sram_wr    = beat_ok & wishbone_we & wishbone_sel & is_sram(wishbone_adr);
    sram_rd    = issue & !wishbone_we & is_sram(nxt_adr);
    sram_idx   = wishbone_we ? wishbone_adr[SRAM_AW-1:0] : nxt_adr[SRAM_AW-1:0];
    tx_push    = beat_ok & wishbone_we & wishbone_sel & is_data(wishbone_adr);
    tx_push_ok = tx_push & (tx_count != FIFO_FULL);
    tx_pop     = (tx_count != '0);
    rx_push    = fifo_stb_rx & !fifo_wait_rx;
    rx_pop     = beat_ok & !wishbone_we & rx_pend;
    rx_avail   = (rx_count - (FAW+1)'(rx_pop)) != '0;
    rx_peek    = rx_rd + FAW'(rx_pop);
    rx_count_nxt = rx_count + (FAW+1)'(rx_push) - (FAW+1)'(rx_pop);
    tx_count_nxt = tx_count + (FAW+1)'(tx_push_ok) - (FAW+1)'(tx_pop);
    status     = {8'd0, 8'(tx_count), 8'(rx_count), 4'd0,
                  tx_overflow, (tx_count == '0), (rx_count == FIFO_FULL), (rx_count == '0)};
  end

  // Read data comes either from the SRAM output register or the register-side mux.
  assign wishbone_dat_r = rsel_sram ? sram_q : reg_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      wishbone_ack <= 1'b0;
      wishbone_err <= 1'b0;
      beat_adr     <= '0;
      beat_we      <= 1'b0;
      rx_pend      <= 1'b0;
      rsel_sram    <= 1'b0;
      reg_q        <= '0;
    end else if (issue) begin
      state        <= (wishbone_cti == CTI_INCR) ? S_BURST : S_SINGLE;
      wishbone_ack <= !nxt_err;
      wishbone_err <= nxt_err;
      beat_adr     <= nxt_adr;
      beat_we      <= wishbone_we;
      rsel_sram    <= sram_rd;
      rx_pend      <= !wishbone_we & is_data(nxt_adr) & rx_avail;
      if (!wishbone_we && is_data(nxt_adr))
        reg_q <= rx_avail ? rx_mem[rx_peek] : 32'd0;
      else if (!wishbone_we && is_stat(nxt_adr))
        reg_q <= status;
      else
        reg_q <= 32'd0;
    end else begin
      state        <= S_IDLE;
      wishbone_ack <= 1'b0;
      wishbone_err <= 1'b0;
      rx_pend      <= 1'b0;
    end
  end

  // Single SRAM port: a write and a prefetch read never coincide (we selects one).
  always_ff @(posedge clk) begin
    if (sram_wr) sram[sram_idx] <= wishbone_dat_w;
    if (sram_rd) sram_q <= sram[sram_idx];
  end

  always_ff @(posedge clk) begin
    if (rx_push)    rx_mem[rx_wr] <= fifo_dat_rx;
    if (tx_push_ok) tx_mem[tx_wr] <= wishbone_dat_w;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_rd        <= '0;
      rx_wr        <= '0;
      tx_rd        <= '0;
      tx_wr        <= '0;
      rx_count     <= '0;
      tx_count     <= '0;
      tx_overflow  <= 1'b0;
      fifo_stb_tx  <= 1'b0;
      fifo_dat_tx  <= '0;
      fifo_wait_rx <= 1'b0;
      fifo_wait_tx <= 1'b1;
    end else begin
      if (rx_push)    rx_wr <= rx_wr + FAW'(1);
      if (rx_pop)     rx_rd <= rx_rd + FAW'(1);
      if (tx_push_ok) tx_wr <= tx_wr + FAW'(1);
      if (tx_pop) begin
        tx_rd       <= tx_rd + FAW'(1);
        fifo_dat_tx <= tx_mem[tx_rd];
      end
      fifo_stb_tx  <= tx_pop;
      rx_count     <= rx_count_nxt;
      tx_count     <= tx_count_nxt;
      tx_overflow  <= tx_overflow | (tx_push & !tx_push_ok);
      fifo_wait_rx <= (rx_count_nxt == FIFO_FULL);
      fifo_wait_tx <= (tx_count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_wb_sram_fifo.sv
// Directed bench for wb_sram_fifo: SRAM classic/burst access, RX fill/drain, TX burst drain, status, out-of-range.
module tb_wb_sram_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_dat_w;
  logic [31:0] wishbone_dat_r;
  logic        wishbone_cyc, wishbone_stb, wishbone_we, wishbone_sel;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;
  logic        wishbone_ack, wishbone_err;
  logic [31:0] fifo_dat_rx;
  logic        fifo_stb_rx, fifo_wait_rx;
  logic [31:0] fifo_dat_tx;
  logic        fifo_stb_tx, fifo_wait_tx;

  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] rx_model[$];
  logic [31:0] exp_tx[$];
  logic [31:0] tx_seen[$];
  int          tx_cyc[$];
  logic [31:0] mdl [int];
  int          vectors = 0;
  int          miscompares = 0;
  int          neg_n = 0;

  wb_sram_fifo dut (
    .clk(clk), .reset(reset),
    .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w), .wishbone_dat_r(wishbone_dat_r),
    .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb), .wishbone_we(wishbone_we),
    .wishbone_sel(wishbone_sel), .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
    .wishbone_ack(wishbone_ack), .wishbone_err(wishbone_err),
    .fifo_dat_rx(fifo_dat_rx), .fifo_stb_rx(fifo_stb_rx), .fifo_wait_rx(fifo_wait_rx),
    .fifo_dat_tx(fifo_dat_tx), .fifo_stb_tx(fifo_stb_tx), .fifo_wait_tx(fifo_wait_tx)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // TX stream monitor
  always @(negedge clk) begin
    neg_n++;
    if (reset && fifo_stb_tx) begin
      tx_seen.push_back(fifo_dat_tx);
      tx_cyc.push_back(neg_n);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone cycle of n beats (n=1 classic, n>1 incrementing burst ending with cti=111).
  task automatic wb_xfer(input string tag, input logic [29:0] a0, input bit inc, input int n,
                         input logic we_i, input logic sel_i, output int cycles, output bit saw_err);
    int i;
    logic [31:0] e;
    i = 0;
    cycles = 0;
    saw_err = 0;
    wishbone_cyc = 1'b1;
    wishbone_stb = 1'b1;
    wishbone_we  = we_i;
    wishbone_sel = sel_i;
    wishbone_adr = a0;
    wishbone_cti = (n > 1) ? 3'b010 : 3'b000;
    wishbone_dat_w = we_i ? wr_q.pop_front() : 32'd0;
    while (i < n && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (wishbone_ack || wishbone_err) begin
        if (wishbone_err) begin
          saw_err = 1;
          check({tag, "_ack_with_err"}, {31'd0, wishbone_ack}, 32'd0);
        end else if (!we_i) begin
          e = exp_q.pop_front();
          check(tag, wishbone_dat_r, e);
        end
        i++;
        @(posedge clk);
        #1;
        if (i < n) begin
          wishbone_adr = inc ? a0 + 30'(i) : a0;
          wishbone_cti = (i == n - 1) ? 3'b111 : 3'b010;
          if (we_i) wishbone_dat_w = wr_q.pop_front();
        end
      end
    end
    check({tag, "_beats"}, i, n);
    wishbone_cyc = 1'b0;
    wishbone_stb = 1'b0;
    wishbone_we  = 1'b0;
    wishbone_cti = 3'b000;
  endtask

  initial begin
    int cyc;
    bit err_f;
    int model_rx;
    int a;
    logic [31:0] d;

    reset = 1'b0;
    wishbone_adr = '0; wishbone_dat_w = '0; wishbone_cyc = 0; wishbone_stb = 0;
    wishbone_we = 0; wishbone_sel = 0; wishbone_cti = 0; wishbone_bte = 0;
    fifo_dat_rx = '0; fifo_stb_rx = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    check("rst_ack", {31'd0, wishbone_ack}, 32'd0);
    check("rst_err", {31'd0, wishbone_err}, 32'd0);
    check("rst_stb_tx", {31'd0, fifo_stb_tx}, 32'd0);
    check("rst_wait_tx", {31'd0, fifo_wait_tx}, 32'd1);
    check("rst_wait_rx", {31'd0, fifo_wait_rx}, 32'd0);
    check("rst_dat_r", wishbone_dat_r, 32'd0);
    exp_q.push_back(32'h0000_0005);
    wb_xfer("rst_status", 30'h2000_0001, 0, 1, 0, 1, cyc, err_f);

    // Classic SRAM write/read and aliasing
    wr_q.push_back(32'hDEAD_BEEF);
    wb_xfer("cls_wr", 30'h5, 0, 1, 1, 1, cyc, err_f);
    check("cls_wr_lat", cyc, 2);
    exp_q.push_back(32'hDEAD_BEEF);
    wb_xfer("cls_rd", 30'h5, 0, 1, 0, 1, cyc, err_f);
    check("cls_rd_lat", cyc, 2);
    exp_q.push_back(32'hDEAD_BEEF);
    wb_xfer("alias_rd", 30'h405, 0, 1, 0, 1, cyc, err_f);
    wr_q.push_back(32'h1234_5678);
    wb_xfer("sel0_wr", 30'h5, 0, 1, 1, 0, cyc, err_f);
    exp_q.push_back(32'hDEAD_BEEF);
    wb_xfer("sel0_rd", 30'h5, 0, 1, 0, 1, cyc, err_f);

    // Burst write then burst read of SRAM 0..7
    for (int i = 0; i < 8; i++) wr_q.push_back(32'(i * 3));
    wb_xfer("bst_wr", 30'h0, 1, 8, 1, 1, cyc, err_f);
    check("bst_wr_cycles", cyc, 9);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 3));
    wb_xfer("bst_rd", 30'h0, 1, 8, 0, 1, cyc, err_f);
    check("bst_rd_cycles", cyc, 9);

    // RX fill: 17 pulses, only 16 fit
    model_rx = 0;
    for (int k = 0; k < 17; k++) begin
      fifo_dat_rx = 32'h100 + 32'(k);
      fifo_stb_rx = 1'b1;
      if (model_rx < 16) begin
        rx_model.push_back(32'h100 + 32'(k));
        model_rx++;
      end
      @(posedge clk);
      #1;
    end
    fifo_stb_rx = 1'b0;
    check("rx_wait_full", {31'd0, fifo_wait_rx}, {31'd0, model_rx == 16});
    exp_q.push_back({16'd0, 8'(model_rx), 8'h06});
    wb_xfer("status_full", 30'h2000_0001, 0, 1, 0, 1, cyc, err_f);
    while (rx_model.size() > 0) begin
      exp_q.push_back(rx_model.pop_front());
      wb_xfer("rx_pop", 30'h2000_0000, 0, 1, 0, 1, cyc, err_f);
    end
    check("rx_wait_drained", {31'd0, fifo_wait_rx}, 32'd0);
    exp_q.push_back(32'd0);
    wb_xfer("rx_pop_empty", 30'h2000_0000, 0, 1, 0, 1, cyc, err_f);
    exp_q.push_back(32'h0000_0005);
    wb_xfer("status_empty", 30'h2000_0001, 0, 1, 0, 1, cyc, err_f);

    // TX burst: 4 words at the fixed data window
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(32'hA0 + 32'(i));
      exp_tx.push_back(32'hA0 + 32'(i));
    end
    wb_xfer("tx_bst", 30'h2000_0000, 0, 4, 1, 1, cyc, err_f);
    repeat (8) @(posedge clk);
    #1;
    check("tx_count", tx_seen.size(), 4);
    for (int k = 0; k < 4 && k < tx_seen.size(); k++) begin
      check("tx_data", tx_seen[k], exp_tx[k]);
      check("tx_consecutive", tx_cyc[k] - tx_cyc[0], k);
    end
    check("tx_wait_idle", {31'd0, fifo_wait_tx}, 32'd1);

    // Out-of-range access
`ifdef WB_ERR_EN
    wb_xfer("oor_rd", 30'h2000_0002, 0, 1, 0, 1, cyc, err_f);
    check("oor_err", {31'd0, err_f}, 32'd1);
`else
    exp_q.push_back(32'd0);
    wb_xfer("oor_rd", 30'h2000_0002, 0, 1, 0, 1, cyc, err_f);
    check("oor_err", {31'd0, err_f}, 32'd0);
`endif
    check("oor_lat", cyc, 2);
    @(negedge clk);
    check("oor_term_ack", {31'd0, wishbone_ack}, 32'd0);
    check("oor_term_err", {31'd0, wishbone_err}, 32'd0);
    @(posedge clk);
    #1;

    // Random classic writes/readback in an SRAM window
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(512, 767);
      d = $urandom;
      mdl[a] = d;
      wr_q.push_back(d);
      wb_xfer("rnd_wr", 30'(a), 0, 1, 1, 1, cyc, err_f);
    end
    foreach (mdl[idx]) begin
      exp_q.push_back(mdl[idx]);
      wb_xfer("rnd_rd", 30'(idx), 0, 1, 0, 1, cyc, err_f);
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("tx_no_extra", tx_seen.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
